// File: rtl/pixel_pkg.sv
// Shared types and constants for the 2x2 pixel array frame sequencer.
// Imported by the stream interface, the capture buffer and the top.
package pixel_pkg;

  localparam int PIX_DW = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_GUARD,
    S_READ1,
    S_OUT1,
    S_READ2,
    S_OUT2,
    S_DONE
  } state_t;

  localparam logic [1:0] IDX_11 = 2'd0;
  localparam logic [1:0] IDX_12 = 2'd1;
  localparam logic [1:0] IDX_21 = 2'd2;
  localparam logic [1:0] IDX_22 = 2'd3;

endpackage

// File: rtl/pixel_array_ctrl_if.sv
// Valid/ready pixel stream carrying one code and its array index.
// The sequencer is the master, the downstream consumer the slave.
interface pix_stream_if
  import pixel_pkg::*;
#(
  parameter int DW = PIX_DW
);
  logic [DW-1:0] data;
  logic [1:0]    idx;
  logic          valid;
  logic          ready;

  modport master (
    output data, idx, valid,
    input  ready
  );

  modport slave (
    input  data, idx, valid,
    output ready
  );
endinterface

// File: rtl/pixel_array_ctrl_pix_out_buf.sv
// Two-entry capture buffer for one pixel row, drained as two stream beats.
// Reused for both rows; the row bit selects the index pair.
module pix_out_buf
  import pixel_pkg::*;
#(
  parameter int DW = PIX_DW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cap,
  input  logic          i_row,
  input  logic [DW-1:0] i_d0,
  input  logic [DW-1:0] i_d1,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_idx,
  output logic          o_valid,
  output logic          o_last
);
  logic [DW-1:0] r_d0;
  logic [DW-1:0] r_d1;
  logic          r_ptr;
  logic          r_row;
  logic          r_valid;
  logic          w_fire;

  assign w_fire = r_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_d0    <= '0;
      r_d1    <= '0;
      r_ptr   <= 1'b0;
      r_row   <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_cap) begin
      r_d0    <= i_d0;
      r_d1    <= i_d1;
      r_row   <= i_row;
      r_ptr   <= 1'b0;
      r_valid <= 1'b1;
    end else if (w_fire) begin
      r_ptr <= ~r_ptr;
      if (r_ptr)
        r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_last  = w_fire & r_ptr;
  assign o_data  = !r_valid ? '0 : (r_ptr ? r_d1 : r_d0);
  assign o_idx   = !r_valid ? IDX_11 :
                   r_row    ? (r_ptr ? IDX_22 : IDX_21) :
                              (r_ptr ? IDX_12 : IDX_11);
endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the 2x2 pixel array: erase, expose, ramp-convert,
// then read each row back and stream its two codes downstream.
module pixel_array_ctrl
  import pixel_pkg::*;
#(
  parameter int DW       = PIX_DW,
  parameter int C_ERASE  = 5,
  parameter int C_EXPOSE = 255,
  parameter int C_CONV   = 255,
  parameter int C_READ   = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_px_reset,
  output logic          o_erase,
  output logic          o_expose,
  output logic          o_ramp_en,
  output logic          o_read1,
  output logic          o_read2,
  inout  wire  [DW-1:0] io_data11,
  inout  wire  [DW-1:0] io_data12,
  inout  wire  [DW-1:0] io_data21,
  inout  wire  [DW-1:0] io_data22,
  pix_stream_if.master  m_pix
);
  localparam int CW = 16;

  state_t        r_state;
  state_t        w_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;
  logic [DW-1:0] r_adc;
  logic          w_zero;
  logic          w_cap;
  logic          w_last;
  logic          w_drv;

  assign w_zero = (r_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
    end
  end

  // One down-counter times every phase; reloaded with length-1 on entry.
  always_comb begin
    w_state = r_state;
    w_cnt   = w_zero ? r_cnt : r_cnt - 1'b1;
    unique case (r_state)
      S_IDLE:
        if (i_start) begin
          w_state = S_ERASE;
          w_cnt   = CW'(C_ERASE - 1);
        end
      S_ERASE:
        if (w_zero) begin
          w_state = S_EXPOSE;
          w_cnt   = CW'(C_EXPOSE - 1);
        end
      S_EXPOSE:
        if (w_zero) begin
          w_state = S_CONVERT;
          w_cnt   = CW'(C_CONV - 1);
        end
      S_CONVERT:
        if (w_zero)
          w_state = S_GUARD;
      S_GUARD: begin
        w_state = S_READ1;
        w_cnt   = CW'(C_READ - 1);
      end
      S_READ1:
        if (w_zero)
          w_state = S_OUT1;
      S_OUT1:
        if (w_last) begin
          w_state = S_READ2;
          w_cnt   = CW'(C_READ - 1);
        end
      S_READ2:
        if (w_zero)
          w_state = S_OUT2;
      S_OUT2:
        if (w_last)
          w_state = S_DONE;
      S_DONE:
        w_state = S_IDLE;
      default:
        w_state = S_IDLE;
    endcase
  end

  // Ramp count holds at its final value instead of wrapping past 2^DW-1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_adc <= '0;
    else if (r_state != S_CONVERT)
      r_adc <= '0;
    else if (!w_zero)
      r_adc <= r_adc + 1'b1;
  end

  assign w_drv     = (r_state == S_CONVERT);
  assign io_data11 = w_drv ? r_adc : {DW{1'bz}};
  assign io_data12 = w_drv ? r_adc : {DW{1'bz}};
  assign io_data21 = w_drv ? r_adc : {DW{1'bz}};
  assign io_data22 = w_drv ? r_adc : {DW{1'bz}};

  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_DONE);
  assign o_erase    = (r_state == S_ERASE);
  assign o_px_reset = (r_state == S_ERASE);
  assign o_expose   = (r_state == S_EXPOSE);
  assign o_ramp_en  = (r_state == S_CONVERT);
  assign o_read1    = (r_state == S_READ1);
  assign o_read2    = (r_state == S_READ2);

  assign w_cap = w_zero &
    ((r_state == S_READ1) | (r_state == S_READ2));

  pix_out_buf #(.DW(DW)) u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_cap   (w_cap),
    .i_row   (r_state == S_READ2),
    .i_d0    ((r_state == S_READ2) ? io_data21 : io_data11),
    .i_d1    ((r_state == S_READ2) ? io_data22 : io_data12),
    .i_ready (m_pix.ready),
    .o_data  (m_pix.data),
    .o_idx   (m_pix.idx),
    .o_valid (m_pix.valid),
    .o_last  (w_last)
  );
endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Bench for pixel_array_ctrl: pixel and bus models, random frames and
// back-pressure, reset abort, and a full-range conversion instance.
module tb_pixel_array_ctrl;
  import pixel_pkg::*;

  localparam int CE  = 2;
  localparam int CX  = 3;
  localparam int CC  = 16;
  localparam int CR  = 1;
  localparam int CC2 = 256;
  localparam logic [7:0] PROBE = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  logic busy, done, pxr, er, ex, rp, r1, r2;
  wire [7:0] d11, d12, d21, d22;
  pix_stream_if s1 ();

  pixel_array_ctrl #(
    .C_ERASE(CE), .C_EXPOSE(CX), .C_CONV(CC), .C_READ(CR)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_busy(busy), .o_done(done), .o_px_reset(pxr),
    .o_erase(er), .o_expose(ex), .o_ramp_en(rp),
    .o_read1(r1), .o_read2(r2),
    .io_data11(d11), .io_data12(d12),
    .io_data21(d21), .io_data22(d22),
    .m_pix(s1)
  );

  logic busy2, done2, pxr2, er2, ex2, rp2, q1, q2;
  wire [7:0] e11, e12, e21, e22;
  pix_stream_if s2 ();
  assign s2.ready = 1'b1;

  pixel_array_ctrl #(
    .C_ERASE(CE), .C_EXPOSE(CX), .C_CONV(CC2), .C_READ(CR)
  ) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2),
    .o_busy(busy2), .o_done(done2), .o_px_reset(pxr2),
    .o_erase(er2), .o_expose(ex2), .o_ramp_en(rp2),
    .o_read1(q1), .o_read2(q2),
    .io_data11(e11), .io_data12(e12),
    .io_data21(e21), .io_data22(e22),
    .m_pix(s2)
  );

  // Pixel models: track the ramp until it passes the trip level.
  logic [7:0] cd1 [4];
  logic [7:0] cd2 [4];
  int tr1 [4];
  int tr2 [4];

  function automatic logic [7:0] bus1(input int i);
    case (i)
      0: bus1 = d11;
      1: bus1 = d12;
      2: bus1 = d21;
      default: bus1 = d22;
    endcase
  endfunction

  function automatic logic [7:0] bus2(input int i);
    case (i)
      0: bus2 = e11;
      1: bus2 = e12;
      2: bus2 = e21;
      default: bus2 = e22;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (er)
        cd1[i] <= 8'd0;
      else if (rp && int'(bus1(i)) <= tr1[i])
        cd1[i] <= bus1(i);
      if (er2)
        cd2[i] <= 8'd0;
      else if (rp2 && int'(bus2(i)) <= tr2[i])
        cd2[i] <= bus2(i);
    end
  end

  logic idle1, idle2;
  assign idle1 = !rp && !r1 && !r2;
  assign idle2 = !rp2 && !q1 && !q2;
  assign d11 = r1 ? cd1[0] : idle1 ? PROBE : 8'bz;
  assign d12 = r1 ? cd1[1] : idle1 ? PROBE : 8'bz;
  assign d21 = r2 ? cd1[2] : idle1 ? PROBE : 8'bz;
  assign d22 = r2 ? cd1[3] : idle1 ? PROBE : 8'bz;
  assign e11 = q1 ? cd2[0] : idle2 ? PROBE : 8'bz;
  assign e12 = q1 ? cd2[1] : idle2 ? PROBE : 8'bz;
  assign e21 = q2 ? cd2[2] : idle2 ? PROBE : 8'bz;
  assign e22 = q2 ? cd2[3] : idle2 ? PROBE : 8'bz;

  int mode = 0;
  int stall = 0;
  int k1 = 0, k2 = 0;
  int ln_er = 0, ln_ex = 0, ln_rp = 0, ln_rp2 = 0;
  logic hold = 1'b0;
  logic [7:0] pd;
  logic [1:0] pi;
  logic [9:0] beats1 [$];
  logic [9:0] beats2 [$];

  always @(negedge clk) begin
    if (mode == 0)
      s1.ready = 1'b1;
    else if (mode == 1)
      s1.ready = 1'($urandom_range(0, 1));
    else if (s1.valid && s1.idx == IDX_12 && stall < 5) begin
      s1.ready = 1'b0;
      stall++;
    end else
      s1.ready = 1'b1;
    #1;
    if (!rst_n) begin
      k1 = 0; k2 = 0; hold = 1'b0;
      ln_er = 0; ln_ex = 0; ln_rp = 0; ln_rp2 = 0;
    end else begin
      check("onehot", 64'($countones({er, ex, rp, r1, r2}) <= 1), 1);
      check("px_reset", pxr, er);
      if (hold) begin
        check("hold_valid", s1.valid, 1);
        check("hold_data", s1.data, pd);
        check("hold_idx", s1.idx, pi);
      end
      hold = s1.valid && !s1.ready;
      pd = s1.data;
      pi = s1.idx;
      if (s1.valid && s1.ready)
        beats1.push_back({s1.idx, s1.data});
      if (s2.valid)
        beats2.push_back({s2.idx, s2.data});
      if (rp) begin
        check("conv_bus11", d11, k1);
        check("conv_bus22", d22, k1);
        k1++;
      end else
        k1 = 0;
      if (rp2) begin
        check("conv2_bus", e21, k2);
        k2++;
      end else
        k2 = 0;
      if (idle1 && busy)
        check("bus_released", {d11, d12, d21, d22}, {4{PROBE}});
      if (er) ln_er++;
      else if (ln_er != 0) begin check("len_erase", ln_er, CE); ln_er = 0; end
      if (ex) ln_ex++;
      else if (ln_ex != 0) begin check("len_expose", ln_ex, CX); ln_ex = 0; end
      if (rp) ln_rp++;
      else if (ln_rp != 0) begin check("len_conv", ln_rp, CC); ln_rp = 0; end
      if (rp2) ln_rp2++;
      else if (ln_rp2 != 0) begin check("len_conv2", ln_rp2, CC2); ln_rp2 = 0; end
    end
  end

  function automatic int clamp(input int t, input int cmax);
    clamp = (t < cmax) ? t : cmax;
  endfunction

  task automatic frame1(input int t0, t1, t2, t3, input int m, input int exp_len);
    int cyc;
    int tr [4];
    tr = '{t0, t1, t2, t3};
    tr1 = tr;
    mode = m;
    stall = 0;
    beats1.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #2;
    cyc = 1;
    check("busy_first", busy, 1);
    while (!done && cyc < 3000) begin
      start = (cyc == 4 || cyc == 20);
      @(negedge clk); #2;
      cyc++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    if (exp_len > 0)
      check("frame_len", cyc, exp_len);
    check("busy_in_done", busy, 1);
    start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    check("done_pulse", done, 0);
    check("idle_after", busy, 0);
    repeat (3) @(negedge clk);
    #2;
    check("no_requeue", busy, 0);
    check("nbeats", beats1.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < beats1.size())
        check("beat", beats1[i], (i << 8) | clamp(tr[i], CC - 1));
  endtask

  task automatic frame2();
    int cyc;
    tr2 = '{300, 255, int'($urandom_range(0, 254)), 0};
    beats2.delete();
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0; #2;
    cyc = 1;
    while (!done2 && cyc < 3000) begin
      @(negedge clk); #2;
      cyc++;
    end
    check("done2_seen", done2, 1);
    check("frame2_len", cyc, CE + CX + CC2 + 1 + 2 * (CR + 2) + 1);
    @(negedge clk); #2;
    check("idle2_after", busy2, 0);
    check("nbeats2", beats2.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < beats2.size())
        check("beat2", beats2[i], (i << 8) | clamp(tr2[i], CC2 - 1));
  endtask

  int seen;

  initial begin
    tr1 = '{0, 0, 0, 0};
    tr2 = '{0, 0, 0, 0};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_valid", s1.valid, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk); #2;
    check("idle_busy", busy, 0);

    frame1(4, 5, 6, 7, 0, CE + CX + CC + 1 + 2 * (CR + 2) + 1);
    frame1(4, 5, 6, 7, 2, CE + CX + CC + 1 + 2 * (CR + 2) + 1 + 5);

    mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("in_expose", ex, 1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs",
      {busy, done, pxr, er, ex, rp, r1, r2, s1.valid, s1.idx, s1.data}, 0);
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk); #2;
      if (done || busy) seen++;
    end
    check("abort_quiet", seen, 0);

    for (int f = 0; f < 6; f++)
      frame1(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
             int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), 1, 0);

    mode = 0;
    frame2();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
endmodule
